charram_dram_ctrl: RTL and testbench

//  Timing generator/arbiter directly upstream of the four 4416 char-RAM planes (px0..px3, 4 bits each).

---
 rtl/charram_pkg.sv | 15 +
 rtl/charram_refresh_timer.sv | 34 +++
 rtl/charram_dram_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_charram_dram_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/charram_pkg.sv
// Shared types and constants for the char-RAM DRAM controller.
// The optional refresh engine is enabled with the CHARRAM_REFRESH_EN macro.
package charram_pkg;
  localparam int ROW_W  = 8;
  localparam int COL_W  = 6;
  localparam int ADDR_W = ROW_W + COL_W;

  typedef enum logic [2:0] {IDLE, ROW, COL, ACC, DATA, REF, PRE} state_t;
  typedef enum logic [1:0] {VID, CPU_RD, CPU_WR, RFSH} acc_t;

  // Column phase address: column bits sit in the middle of the 8-bit bus.
  function automatic logic [7:0] col_addr(input logic [ADDR_W-1:0] a);
    return {1'b0, a[ADDR_W-1:ROW_W], 1'b0};
  endfunction
endpackage

// File: rtl/charram_refresh_timer.sv
// Refresh interval counter and refresh row counter.
// Used only when CHARRAM_REFRESH_EN is defined.
module charram_refresh_timer
  import charram_pkg::*;
#(
  parameter int INTERVAL = 64
) (
  input  logic             i_MCLK,
  input  logic             i_RST_n,
  input  logic             i_CEN,
  input  logic             i_row_inc,
  output logic             o_tick,
  output logic [ROW_W-1:0] o_row
);
  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0] LAST = CW'(INTERVAL - 1);

  logic [CW-1:0]    r_int;
  logic [ROW_W-1:0] r_row;

  // Interval counter runs on sequencer ticks; row counter advances per serviced refresh.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_int <= '0;
      r_row <= '0;
    end else begin
      if (i_CEN) r_int <= (r_int == LAST) ? '0 : r_int + 1'b1;
      if (i_row_inc) r_row <= r_row + 1'b1;
    end
  end

  assign o_tick = i_CEN && (r_int == LAST);
  assign o_row  = r_row;
endmodule

// File: rtl/charram_dram_ctrl.sv
// Char-RAM DRAM timing generator: arbitrates video fetch, CPU access and
// (with CHARRAM_REFRESH_EN defined) RAS-only refresh onto four 4416 planes.
module charram_dram_ctrl
  import charram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 64,
  parameter int PLANES           = 4
) (
  input  logic                i_MCLK,
  input  logic                i_RST_n,
  input  logic                i_CEN,
  input  logic                i_VREQ,
  input  logic [ADDR_W-1:0]   i_VADDR,
  output logic [4*PLANES-1:0] o_VDATA,
  output logic                o_VDATA_VLD,
  output logic                o_VOVF,
  input  logic                i_CPU_REQ,
  input  logic                i_CPU_WR_n,
  input  logic [ADDR_W-1:0]   i_CPU_ADDR,
  input  logic [4*PLANES-1:0] i_CPU_DIN,
  output logic [4*PLANES-1:0] o_CPU_DOUT,
  output logic                o_DTACK_n,
  output logic [7:0]          o_DRAM_ADDR,
  output logic                o_RAS_n,
  output logic                o_CAS_n,
  output logic                o_WR_n,
  output logic                o_RD_n,
  output logic [4*PLANES-1:0] o_DRAM_DIN,
  input  logic [4*PLANES-1:0] i_DRAM_DOUT
);
  localparam int DW = 4 * PLANES;

  state_t            r_state, w_state_next;
  acc_t              r_acc, w_grant_acc;
  logic [ADDR_W-1:0] r_addr, w_grant_addr, r_vaddr;
  logic [DW-1:0]     r_wdata, r_din, r_vdata, r_cpu_dout;
  logic [7:0]        r_dram_addr;
  logic              r_ras_n, r_cas_n, r_wr_n, r_rd_n;
  logic              r_vpend, r_vovf, r_vvld, r_cpu_served, r_cpu_drop;
  logic              w_grant, w_grant_en, w_capture, w_vid_grant;
  logic              w_ras_on, w_cas_on, w_xfer;
  logic              w_rfsh_due;
  logic [ROW_W-1:0]  w_rfsh_row;

`ifdef CHARRAM_REFRESH_EN
  logic w_rfsh_tick, w_rfsh_inc, r_rfsh_due;

  charram_refresh_timer #(.INTERVAL(REFRESH_INTERVAL)) u_refresh_timer (
    .i_MCLK    (i_MCLK),
    .i_RST_n   (i_RST_n),
    .i_CEN     (i_CEN),
    .i_row_inc (w_rfsh_inc),
    .o_tick    (w_rfsh_tick),
    .o_row     (w_rfsh_row)
  );

  assign w_rfsh_inc = w_grant_en && (w_grant_acc == RFSH);
  assign w_rfsh_due = r_rfsh_due;

  // Refresh-due flag: repeated terminal counts before service collapse into one.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n)         r_rfsh_due <= 1'b0;
    else if (w_rfsh_tick) r_rfsh_due <= 1'b1;
    else if (w_rfsh_inc)  r_rfsh_due <= 1'b0;
  end
`else
  assign w_rfsh_due = 1'b0;
  assign w_rfsh_row = '0;
`endif

  // Arbitration in IDLE (video > refresh > new CPU request) and next-state/strobe decode.
  always_comb begin
    w_grant      = 1'b0;
    w_grant_acc  = r_acc;
    w_grant_addr = r_addr;
    w_state_next = r_state;
    if (r_state == IDLE) begin
      if (r_vpend || i_VREQ) begin
        w_grant      = 1'b1;
        w_grant_acc  = VID;
        w_grant_addr = r_vpend ? r_vaddr : i_VADDR;
      end else if (w_rfsh_due) begin
        w_grant      = 1'b1;
        w_grant_acc  = RFSH;
        w_grant_addr = {{(ADDR_W-ROW_W){1'b0}}, w_rfsh_row};
      end else if (i_CPU_REQ && !r_cpu_served) begin
        w_grant      = 1'b1;
        w_grant_acc  = i_CPU_WR_n ? CPU_RD : CPU_WR;
        w_grant_addr = i_CPU_ADDR;
      end
    end
    if (i_CEN) begin
      case (r_state)
        IDLE:    if (w_grant) w_state_next = ROW;
        ROW:     w_state_next = (r_acc == RFSH) ? REF : COL;
        COL:     w_state_next = ACC;
        ACC:     w_state_next = DATA;
        DATA:    w_state_next = PRE;
        REF:     w_state_next = PRE;
        PRE:     w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
    w_ras_on = (w_state_next != IDLE) && (w_state_next != PRE);
    w_cas_on = (w_state_next == COL) || (w_state_next == ACC) || (w_state_next == DATA);
    w_xfer   = (w_state_next == ACC) || (w_state_next == DATA);
  end

  assign w_grant_en  = i_CEN && w_grant;
  assign w_vid_grant = w_grant_en && (w_grant_acc == VID);
  assign w_capture   = i_CEN && (r_state == DATA);

  // State register plus registered strobes/address, all advancing on sequencer ticks.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state     <= IDLE;
      r_acc       <= VID;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_din       <= '0;
      r_dram_addr <= '0;
      r_ras_n     <= 1'b1;
      r_cas_n     <= 1'b1;
      r_wr_n      <= 1'b1;
      r_rd_n      <= 1'b1;
    end else if (i_CEN) begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_acc   <= w_grant_acc;
        r_addr  <= w_grant_addr;
        r_wdata <= i_CPU_DIN;
      end
      r_ras_n <= ~w_ras_on;
      r_cas_n <= ~w_cas_on;
      r_wr_n  <= ~(w_xfer && (r_acc == CPU_WR));
      r_rd_n  <= ~(w_xfer && (r_acc != CPU_WR));
      r_din   <= (w_xfer && (r_acc == CPU_WR)) ? r_wdata : '0;
      if (w_state_next == ROW)      r_dram_addr <= w_grant_addr[ROW_W-1:0];
      else if (w_state_next == COL) r_dram_addr <= col_addr(r_addr);
    end
  end

  // Video pending/overflow: a request landing on an already pending one merges and flags overflow.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_vpend <= 1'b0;
      r_vaddr <= '0;
      r_vovf  <= 1'b0;
    end else if (i_CEN) begin
      if (i_VREQ) begin
        if (r_vpend && !w_vid_grant) r_vovf <= 1'b1;
        if (r_vpend || !w_vid_grant) begin
          r_vpend <= 1'b1;
          r_vaddr <= i_VADDR;
        end
      end else if (w_vid_grant) begin
        r_vpend <= 1'b0;
      end
    end
  end

  // Completion responses; pulses and DTACK release run on every MCLK regardless of i_CEN.
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_vdata      <= '0;
      r_vvld       <= 1'b0;
      r_cpu_dout   <= '0;
      r_cpu_served <= 1'b0;
      r_cpu_drop   <= 1'b0;
    end else begin
      r_vvld <= 1'b0;
      if (!i_CPU_REQ) r_cpu_served <= 1'b0;
      if (w_grant_en)                           r_cpu_drop <= 1'b0;
      else if (!i_CPU_REQ && r_state != IDLE)   r_cpu_drop <= 1'b1;
      if (w_capture) begin
        if (r_acc == VID) begin
          r_vdata <= i_DRAM_DOUT;
          r_vvld  <= 1'b1;
        end else if ((r_acc == CPU_RD || r_acc == CPU_WR) && i_CPU_REQ && !r_cpu_drop) begin
          r_cpu_served <= 1'b1;
          if (r_acc == CPU_RD) r_cpu_dout <= i_DRAM_DOUT;
        end
      end
    end
  end

  assign o_VDATA     = r_vdata;
  assign o_VDATA_VLD = r_vvld;
  assign o_VOVF      = r_vovf;
  assign o_CPU_DOUT  = r_cpu_dout;
  assign o_DTACK_n   = ~r_cpu_served;
  assign o_DRAM_ADDR = r_dram_addr;
  assign o_RAS_n     = r_ras_n;
  assign o_CAS_n     = r_cas_n;
  assign o_WR_n      = r_wr_n;
  assign o_RD_n      = r_rd_n;
  assign o_DRAM_DIN  = r_din;
endmodule

// File: tb/tb_charram_dram_ctrl.sv
// Directed bench for charram_dram_ctrl with a small behavioural 4416 plane model.
// With CHARRAM_REFRESH_EN defined only the refresh sequence is exercised.
module tb_charram_dram_ctrl;
  logic        i_MCLK = 1'b0;
  logic        i_RST_n, i_CEN, i_VREQ, i_CPU_REQ, i_CPU_WR_n;
  logic [13:0] i_VADDR, i_CPU_ADDR;
  logic [15:0] i_CPU_DIN;
  logic [15:0] i_DRAM_DOUT = '0;
  logic [15:0] o_VDATA, o_CPU_DOUT, o_DRAM_DIN;
  logic        o_VDATA_VLD, o_VOVF, o_DTACK_n, o_RAS_n, o_CAS_n, o_WR_n, o_RD_n;
  logic [7:0]  o_DRAM_ADDR;

  int n_vec = 0;
  int n_err = 0;

  charram_dram_ctrl #(.REFRESH_INTERVAL(4), .PLANES(4)) dut (
    .i_MCLK(i_MCLK), .i_RST_n(i_RST_n), .i_CEN(i_CEN),
    .i_VREQ(i_VREQ), .i_VADDR(i_VADDR), .o_VDATA(o_VDATA), .o_VDATA_VLD(o_VDATA_VLD),
    .o_VOVF(o_VOVF), .i_CPU_REQ(i_CPU_REQ), .i_CPU_WR_n(i_CPU_WR_n), .i_CPU_ADDR(i_CPU_ADDR),
    .i_CPU_DIN(i_CPU_DIN), .o_CPU_DOUT(o_CPU_DOUT), .o_DTACK_n(o_DTACK_n),
    .o_DRAM_ADDR(o_DRAM_ADDR), .o_RAS_n(o_RAS_n), .o_CAS_n(o_CAS_n), .o_WR_n(o_WR_n),
    .o_RD_n(o_RD_n), .o_DRAM_DIN(o_DRAM_DIN), .i_DRAM_DOUT(i_DRAM_DOUT)
  );

  always #5 i_MCLK = ~i_MCLK;

  // Background contents of locations never written.
  function automatic logic [15:0] pat(input logic [13:0] a);
    return {2'b00, a} ^ 16'hC3C3;
  endfunction

  // DRAM plane model: latch row/column on strobe falls, write on WR_n, registered read.
  logic        m_ras_q = 1'b1, m_cas_q = 1'b1;
  logic [7:0]  m_row = '0;
  logic [5:0]  m_col = '0;
  logic [15:0] mem [0:16383];
  bit          written [0:16383];
  always @(posedge i_MCLK) begin
    m_ras_q <= o_RAS_n;
    m_cas_q <= o_CAS_n;
    if (m_ras_q && !o_RAS_n) m_row <= o_DRAM_ADDR;
    if (m_cas_q && !o_CAS_n) m_col <= o_DRAM_ADDR[6:1];
    if (!o_WR_n && !o_CAS_n) begin
      mem[{m_col, m_row}]     <= o_DRAM_DIN;
      written[{m_col, m_row}] <= 1'b1;
    end
    i_DRAM_DOUT <= !o_RD_n ? (written[{m_col, m_row}] ? mem[{m_col, m_row}] : pat({m_col, m_row})) : 16'h0;
  end

  task automatic step();
    @(posedge i_MCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_vec++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
    end
  endtask

  // Full CPU access from IDLE with strobe/address checks in every state.
  task automatic cpu_txn(input bit wr, input logic [13:0] a, input logic [15:0] d, input logic [15:0] exp_dout);
    logic [7:0] col;
    col = {1'b0, a[13:8], 1'b0};
    i_CPU_REQ = 1'b1; i_CPU_WR_n = ~wr; i_CPU_ADDR = a; i_CPU_DIN = d;
    step();
    chk("row_ras_cas", {o_RAS_n, o_CAS_n}, 2'b01);
    chk("row_addr", o_DRAM_ADDR, a[7:0]);
    step();
    chk("col_ras_cas", {o_RAS_n, o_CAS_n}, 2'b00);
    chk("col_addr", o_DRAM_ADDR, col);
    step();
    chk("acc_wr_rd", {o_WR_n, o_RD_n}, {~wr, wr});
    if (wr) chk("acc_din", o_DRAM_DIN, d);
    step();
    chk("data_wr_rd", {o_WR_n, o_RD_n}, {~wr, wr});
    chk("data_dtack", o_DTACK_n, 1'b1);
    step();
    chk("done_dtack", o_DTACK_n, 1'b0);
    chk("pre_strobes", {o_RAS_n, o_CAS_n, o_WR_n, o_RD_n}, 4'hF);
    if (!wr) chk("cpu_dout", o_CPU_DOUT, exp_dout);
    i_CPU_REQ = 1'b0;
    #2;
    chk("dtack_held", o_DTACK_n, 1'b0);
    step();
    chk("dtack_release", o_DTACK_n, 1'b1);
    $display("txn cpu %s addr=%h data=%h", wr ? "wr" : "rd", a, wr ? d : o_CPU_DOUT);
  endtask

  int         vcnt;
  bit         dt_seen;
  logic [7:0] exp_row;
  int         nref;
  bit         cas_low;
  logic       prev_ras;

  initial begin
    i_RST_n = 1'b0; i_CEN = 1'b1; i_VREQ = 1'b0; i_VADDR = '0;
    i_CPU_REQ = 1'b0; i_CPU_WR_n = 1'b1; i_CPU_ADDR = '0; i_CPU_DIN = '0;
    repeat (3) step();
    chk("rst_strobes", {o_RAS_n, o_CAS_n, o_WR_n, o_RD_n}, 4'hF);
    chk("rst_dtack", o_DTACK_n, 1'b1);
    chk("rst_vld_ovf", {o_VDATA_VLD, o_VOVF}, 2'b00);
    chk("rst_addr", o_DRAM_ADDR, 8'h00);
    chk("rst_data", {o_VDATA, o_CPU_DOUT}, 32'h0);
    $display("txn reset");
    i_RST_n = 1'b1;
    step();

`ifdef CHARRAM_REFRESH_EN
    exp_row = 8'h00; nref = 0; cas_low = 1'b0; prev_ras = 1'b1;
    for (int c = 0; c < 3000 && nref < 260; c++) begin
      step();
      if (!o_CAS_n) cas_low = 1'b1;
      if (prev_ras && !o_RAS_n) begin
        chk("rfsh_row", o_DRAM_ADDR, exp_row);
        exp_row = exp_row + 8'd1;
        nref++;
      end
      prev_ras = o_RAS_n;
    end
    chk("rfsh_count", nref, 260);
    chk("rfsh_cas_high", cas_low, 1'b0);
    $display("txn refresh cycles=%0d", nref);
`else
    // Write then read back the same word.
    cpu_txn(1'b1, 14'h2A5B, 16'h1234, 16'h0000);
    cpu_txn(1'b0, 14'h2A5B, 16'h0000, 16'h1234);

    // Video and CPU in the same IDLE tick: video at T0..T4, CPU granted T6, DTACK at T10.
    i_VREQ = 1'b1; i_VADDR = 14'h0345;
    i_CPU_REQ = 1'b1; i_CPU_WR_n = 1'b1; i_CPU_ADDR = 14'h2A5B;
    for (int k = 0; k <= 10; k++) begin
      step();
      i_VREQ = 1'b0;
      chk("arb_vld", o_VDATA_VLD, (k == 4));
      chk("arb_dtack", o_DTACK_n, (k < 10));
      if (k == 4) chk("arb_vdata", o_VDATA, pat(14'h0345));
      if (k == 6) chk("arb_cpu_row", {o_RAS_n, o_DRAM_ADDR}, {1'b0, 8'h5B});
      if (k == 10) chk("arb_cpu_dout", o_CPU_DOUT, 16'h1234);
    end
    i_CPU_REQ = 1'b0;
    step();
    chk("arb_release", o_DTACK_n, 1'b1);
    $display("txn video+cpu vdata=%h cpu=%h", o_VDATA, o_CPU_DOUT);

    // i_CEN low holds state and strobes mid-access.
    i_CPU_REQ = 1'b1; i_CPU_WR_n = 1'b1; i_CPU_ADDR = 14'h2A5B;
    step();
    i_CEN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("cen_hold", {o_RAS_n, o_CAS_n, o_DRAM_ADDR}, {2'b01, 8'h5B});
    end
    i_CEN = 1'b1;
    step();
    chk("cen_resume_col", {o_CAS_n, o_DRAM_ADDR}, {1'b0, 8'h54});
    repeat (3) step();
    chk("cen_dtack", {o_DTACK_n, o_CPU_DOUT}, {1'b0, 16'h1234});
    i_CPU_REQ = 1'b0;
    step();
    $display("txn cpu rd with cen gap dout=%h", o_CPU_DOUT);

    // Half-rate i_CEN: VDATA_VLD is still exactly one MCLK wide.
    i_VREQ = 1'b1; i_VADDR = 14'h1ABC;
    step();
    i_VREQ = 1'b0;
    vcnt = 0;
    for (int k = 1; k <= 24; k++) begin
      i_CEN = (k % 2 == 0);
      step();
      if (o_VDATA_VLD) begin
        vcnt++;
        chk("half_vdata", o_VDATA, pat(14'h1ABC));
      end
    end
    i_CEN = 1'b1;
    chk("half_vld_width", vcnt, 1);
    $display("txn video half-rate pulses=%0d", vcnt);

    // Two video requests while busy: overflow, one merged fetch from the latest address.
    i_CPU_REQ = 1'b1; i_CPU_WR_n = 1'b1; i_CPU_ADDR = 14'h1111;
    step();
    i_VREQ = 1'b1; i_VADDR = 14'h0100;
    step();
    i_VADDR = 14'h0200;
    step();
    i_VREQ = 1'b0;
    chk("ovf_set", o_VOVF, 1'b1);
    vcnt = 0; dt_seen = 1'b0;
    for (int k = 3; k <= 16; k++) begin
      step();
      if (!o_DTACK_n && i_CPU_REQ) begin
        chk("ovf_cpu_dout", o_CPU_DOUT, pat(14'h1111));
        dt_seen = 1'b1;
        i_CPU_REQ = 1'b0;
      end
      if (k == 7) chk("ovf_col_addr", o_DRAM_ADDR, 8'h04);
      if (o_VDATA_VLD) begin
        vcnt++;
        chk("ovf_vdata", o_VDATA, pat(14'h0200));
      end
    end
    chk("ovf_fetches", vcnt, 1);
    chk("ovf_cpu_done", dt_seen, 1'b1);
    $display("txn video overflow merge vdata=%h", o_VDATA);

    // Reset during COL aborts immediately and nothing completes afterwards.
    i_CPU_REQ = 1'b1; i_CPU_WR_n = 1'b1; i_CPU_ADDR = 14'h0ABC;
    step();
    step();
    chk("rst_mid_col", o_CAS_n, 1'b0);
    #2;
    i_RST_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {o_RAS_n, o_CAS_n, o_WR_n, o_RD_n}, 4'hF);
    chk("rst_mid_addr_ovf", {o_DRAM_ADDR, o_VOVF, o_DTACK_n}, {8'h00, 1'b0, 1'b1});
    i_CPU_REQ = 1'b0;
    step();
    i_RST_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rst_after", {o_DTACK_n, o_RAS_n}, 2'b11);
    end
    $display("txn reset during access");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
